// File: rtl/snake_game_sequencer_if.sv
// Request/done handshake between the game-flow sequencer (master) and the snake engine (slave).
interface snake_game_sequencer_if;
    logic step_req;
    logic engine_clear;
    logic step_done;
    logic step_collide;
    logic step_ate;

    modport master (
        output step_req,
        output engine_clear,
        input  step_done,
        input  step_collide,
        input  step_ate
    );

    modport slave (
        input  step_req,
        input  engine_clear,
        output step_done,
        output step_collide,
        output step_ate
    );
endinterface

// File: rtl/snake_game_sequencer.sv
// Game-flow controller for the 8x8 snake: move cadence, engine step handshake,
// speed levels, pause and death-flash phases, and display blanking.
module snake_game_sequencer #(
    parameter int TICK_DIV      = 5_000_000,
    parameter int START_PERIOD  = 8,
    parameter int MIN_PERIOD    = 2,
    parameter int SPEEDUP_EVERY = 4,
    parameter int FLASH_COUNT   = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pause,
    snake_game_sequencer_if.master eng,
    output logic                   display_blank,
    output logic [2:0]             state,
    output logic [3:0]             level,
    output logic [4:0]             period
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FL_W  = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST         = PRE_W'(TICK_DIV - 1);
    localparam logic [FL_W-1:0]  FL_LAST          = FL_W'(FLASH_COUNT - 1);
    localparam logic [4:0]       PERIOD_START     = 5'(START_PERIOD);
    localparam logic [4:0]       PERIOD_MIN       = 5'(MIN_PERIOD);
    localparam logic [3:0]       APPLES_PER_LEVEL = 4'(SPEEDUP_EVERY);
    localparam logic [3:0]       LEVEL_MAX        = 4'd15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        PAUSE = 3'd4,
        DYING = 3'd5,
        OVER  = 3'd6
    } state_t;

    state_t            state_reg, state_next;
    logic [PRE_W-1:0]  presc_reg, presc_next;
    logic [4:0]        tick_cnt_reg, tick_cnt_next;
    logic [FL_W-1:0]   flash_cnt_reg, flash_cnt_next;
    logic [3:0]        apples_reg, apples_next;
    logic [3:0]        level_reg, level_next;
    logic [4:0]        period_reg, period_next;
    logic              blank_reg, blank_next;
    logic              step_req_reg, step_req_next;
    logic              clear_reg, clear_next;

    logic [1:0] btn_in;
    logic [1:0] press;
    logic       start_press;
    logic       pause_press;
    logic       tick;
    logic       move_due;
    logic [3:0] apple_inc;

    assign btn_in      = {pause, start};
    assign start_press = press[0];
    assign pause_press = press[1];

    // Buttons are edge-detected into registered one-cycle press pulses. The
    // previous-level registers reset high so a button held through reset is not a press.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic d_reg;
            logic p_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    d_reg <= 1'b1;
                    p_reg <= 1'b0;
                end else begin
                    d_reg <= btn_in[gi];
                    p_reg <= btn_in[gi] & ~d_reg;
                end
            end
            assign press[gi] = p_reg;
        end
    endgenerate

    assign tick     = (presc_reg == PRE_LAST);
    assign move_due = tick && (tick_cnt_reg == period_reg - 5'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            presc_reg     <= '0;
            tick_cnt_reg  <= '0;
            flash_cnt_reg <= '0;
            apples_reg    <= '0;
            level_reg     <= '0;
            period_reg    <= PERIOD_START;
            blank_reg     <= 1'b0;
            step_req_reg  <= 1'b0;
            clear_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            tick_cnt_reg  <= tick_cnt_next;
            flash_cnt_reg <= flash_cnt_next;
            apples_reg    <= apples_next;
            level_reg     <= level_next;
            period_reg    <= period_next;
            blank_reg     <= blank_next;
            step_req_reg  <= step_req_next;
            clear_reg     <= clear_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        presc_next     = presc_reg;
        tick_cnt_next  = tick_cnt_reg;
        flash_cnt_next = flash_cnt_reg;
        apples_next    = apples_reg;
        level_next     = level_reg;
        period_next    = period_reg;
        blank_next     = blank_reg;
        apple_inc      = apples_reg + 4'd1;

        case (state_reg)
            IDLE, OVER: begin
                if (start_press) state_next = CLEAR;
            end
            CLEAR: begin
                level_next     = '0;
                period_next    = PERIOD_START;
                apples_next    = '0;
                presc_next     = '0;
                tick_cnt_next  = '0;
                flash_cnt_next = '0;
                state_next     = RUN;
            end
            RUN: begin
                // Counters keep advancing in the cycle a pause press is seen; a move
                // falling due in that same cycle takes priority and the press is dropped.
                presc_next = tick ? '0 : presc_reg + 1'b1;
                if (move_due) begin
                    tick_cnt_next = '0;
                    state_next    = STEP;
                end else begin
                    if (tick) tick_cnt_next = tick_cnt_reg + 5'd1;
                    if (pause_press) state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_press) state_next = RUN;
            end
            STEP: begin
                presc_next = '0;
                if (eng.step_done) begin
                    if (eng.step_collide) begin
                        state_next     = DYING;
                        flash_cnt_next = '0;
                        blank_next     = 1'b1;
                    end else begin
                        state_next = RUN;
                        if (eng.step_ate) begin
                            if (apple_inc == APPLES_PER_LEVEL) begin
                                apples_next = '0;
                                if (level_reg != LEVEL_MAX) level_next = level_reg + 4'd1;
                                if (period_reg > PERIOD_MIN) period_next = period_reg - 5'd1;
                            end else begin
                                apples_next = apple_inc;
                            end
                        end
                    end
                end
            end
            DYING: begin
                presc_next = tick ? '0 : presc_reg + 1'b1;
                if (tick) begin
                    if (flash_cnt_reg == FL_LAST) begin
                        flash_cnt_next = '0;
                        blank_next     = 1'b0;
                        state_next     = OVER;
                    end else begin
                        flash_cnt_next = flash_cnt_reg + 1'b1;
                        blank_next     = ~blank_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Handshake outputs are registered copies of the upcoming state.
        step_req_next = (state_next == STEP);
        clear_next    = (state_next == CLEAR);
    end

    assign eng.step_req     = step_req_reg;
    assign eng.engine_clear = clear_reg;
    assign display_blank    = blank_reg;
    assign state            = state_reg;
    assign level            = level_reg;
    assign period           = period_reg;
endmodule

// File: tb/tb_snake_game_sequencer.sv
// Scoreboard bench for snake_game_sequencer: stimulus queues expected step/clear
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_snake_game_sequencer;
    localparam int TICK_DIV      = 4;
    localparam int START_PERIOD  = 3;
    localparam int MIN_PERIOD    = 1;
    localparam int SPEEDUP_EVERY = 2;
    localparam int FLASH_COUNT   = 4;

    localparam int K_STEP  = 0;
    localparam int K_CLEAR = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pause;
    logic       display_blank;
    logic [2:0] state;
    logic [3:0] level;
    logic [4:0] period;

    snake_game_sequencer_if eng();

    snake_game_sequencer #(
        .TICK_DIV     (TICK_DIV),
        .START_PERIOD (START_PERIOD),
        .MIN_PERIOD   (MIN_PERIOD),
        .SPEEDUP_EVERY(SPEEDUP_EVERY),
        .FLASH_COUNT  (FLASH_COUNT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .eng          (eng.master),
        .display_blank(display_blank),
        .state        (state),
        .level        (level),
        .period       (period)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int run_cycles;
        int lvl;
        int per;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_level;
    int   m_period;
    int   m_apples;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int kind, input int runc, input int lvl, input int per);
        exp_t e;
        e.kind = kind; e.run_cycles = runc; e.lvl = lvl; e.per = per;
        sb.push_back(e);
    endtask

    // Monitor: counts RUN cycles between moves and checks each step_req rise and
    // each engine_clear pulse against the next queued expectation.
    initial begin
        int   run_cnt;
        bit   req_prev;
        bit   clr_prev;
        exp_t e;
        run_cnt = 0; req_prev = 0; clr_prev = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run_cnt = 0; req_prev = 0; clr_prev = 0;
            end else begin
                if (state == 3'd2) run_cnt++;
                if (clr_prev) check("engine_clear_width", eng.engine_clear, 0);
                if (eng.engine_clear && !clr_prev) begin
                    run_cnt = 0;
                    $display("engine_clear: level=%0d period=%0d", level, period);
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_clear: got engine_clear, expected no event");
                    end else begin
                        e = sb.pop_front();
                        check("event_kind_clear", K_CLEAR, e.kind);
                    end
                end
                if (eng.step_req && !req_prev) begin
                    $display("step_req: run_cycles=%0d level=%0d period=%0d", run_cnt, level, period);
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_step: got step_req, expected no event");
                    end else begin
                        e = sb.pop_front();
                        check("event_kind_step", K_STEP, e.kind);
                        check("run_cycles", run_cnt, e.run_cycles);
                        check("step_level", level, e.lvl);
                        check("step_period", period, e.per);
                    end
                    run_cnt = 0;
                end
                req_prev = eng.step_req;
                clr_prev = eng.engine_clear;
            end
        end
    end

    task automatic wait_step_req(input string name, output int n);
        n = 0;
        while (!eng.step_req && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!eng.step_req) begin
            checks++; failures++;
            $display("FAIL %s: step_req still low after %0d cycles, expected high", name, n);
        end
    endtask

    // Answers the pending request two cycles after it is seen; the model then
    // predicts the level/period the next request should carry.
    task automatic answer(input bit c, input bit a);
        repeat (2) @(negedge clk);
        eng.step_done = 1'b1; eng.step_collide = c; eng.step_ate = a;
        @(negedge clk);
        eng.step_done = 1'b0; eng.step_collide = 1'b0; eng.step_ate = 1'b0;
        check("step_req_drop", eng.step_req, 0);
        check("post_step_state", state, c ? 5 : 2);
        if (!c) begin
            if (a) begin
                m_apples++;
                if (m_apples == SPEEDUP_EVERY) begin
                    m_apples = 0;
                    if (m_level < 15) m_level++;
                    if (m_period > MIN_PERIOD) m_period--;
                end
            end
            push_exp(K_STEP, m_period * TICK_DIV, m_level, m_period);
        end
    endtask

    task automatic start_game();
        start = 1'b0;
        @(negedge clk);
        m_level = 0; m_period = START_PERIOD; m_apples = 0;
        push_exp(K_CLEAR, 0, 0, 0);
        push_exp(K_STEP, START_PERIOD * TICK_DIV, 0, START_PERIOD);
        start = 1'b1;
        @(negedge clk);
        check("press_latency", state, 3'd0 == state ? 0 : 6);
        @(negedge clk);
        check("clear_state", state, 1);
        check("clear_pulse", eng.engine_clear, 1);
        @(negedge clk);
        check("run_entry_state", state, 2);
        check("run_entry_level", level, 0);
        check("run_entry_period", period, START_PERIOD);
    endtask

    initial begin
        int n;
        int exp_lvl [4];
        int exp_per [4];
        exp_lvl = '{0, 1, 1, 2};
        exp_per = '{3, 2, 2, 1};

        reset = 1'b1; start = 1'b1; pause = 1'b0;
        eng.step_done = 1'b0; eng.step_collide = 1'b0; eng.step_ate = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_step_req", eng.step_req, 0);
        check("rst_engine_clear", eng.engine_clear, 0);
        check("rst_blank", display_blank, 0);
        check("rst_level", level, 0);
        check("rst_period", period, START_PERIOD);

        // Start held high through reset release is not a press.
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_hold_start", state, 0);

        start_game();
        wait_step_req("first_step", n);
        check("first_step_latency", n, START_PERIOD * TICK_DIV);

        answer(0, 0);
        wait_step_req("second_step", n);
        check("step_interval", n, START_PERIOD * TICK_DIV);
        answer(0, 0);

        // Pause two cycles into RUN (prescaler reaches 2 as PAUSE is entered).
        pause = 1'b1;
        repeat (2) @(negedge clk);
        check("pause_entered", state, 4);
        pause = 1'b0;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        repeat (47) @(negedge clk);
        check("pause_holds", state, 4);
        check("pause_no_req", eng.step_req, 0);
        pause = 1'b1;
        wait_step_req("resume_step", n);
        check("resume_latency", n, 12);

        // Pause press while a move is pending is dropped.
        pause = 1'b0;
        @(negedge clk);
        pause = 1'b1;
        answer(0, 0);

        for (int i = 0; i < 4; i++) begin
            wait_step_req("ate_step", n);
            answer(0, 1);
            check("ate_level", level, exp_lvl[i]);
            check("ate_period", period, exp_per[i]);
        end
        for (int i = 0; i < 28; i++) begin
            wait_step_req("sat_step", n);
            answer(0, 1);
        end
        check("sat_level", level, 15);
        check("sat_period", period, MIN_PERIOD);

        // Collision beats apple; blank flashes 1,0,1,0 one tick each.
        wait_step_req("death_step", n);
        answer(1, 1);
        check("dying_level", level, 15);
        for (int i = 0; i < 16; i++) begin
            check("flash_blank", display_blank, ((i / TICK_DIV) % 2 == 0) ? 1 : 0);
            check("flash_state", state, 5);
            @(negedge clk);
        end
        check("over_state", state, 6);
        check("over_blank", display_blank, 0);

        start_game();
        for (int i = 0; i < 2; i++) begin
            wait_step_req("pre_reset_step", n);
            answer(0, 1);
        end
        check("pre_reset_level", level, 1);
        wait_step_req("reset_step", n);

        // Asynchronous reset mid-STEP, checked before the next clock edge.
        reset = 1'b1;
        #1;
        check("async_step_req", eng.step_req, 0);
        check("async_state", state, 0);
        check("async_level", level, 0);
        check("async_period", period, START_PERIOD);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        eng.step_done = 1'b1; eng.step_collide = 1'b1;
        @(negedge clk);
        eng.step_done = 1'b0; eng.step_collide = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_done_state", state, 0);
        check("stray_done_req", eng.step_req, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/snake_game_sequencer.md
# snake_game_sequencer

Game-flow controller for the 8x8 snake game. It owns the move cadence and sequences the snake engine through a request/done handshake. It clears the engine on new games, tracks apples to raise speed, and runs pause and death-flash phases. It sits between the buttons/clock domain and the snake engine, and drives the matrix blanking used by the display scanner.

## Interface
- TICK_DIV, 5_000_000: clk cycles per base tick (prescaler terminal count + 1).
- START_PERIOD, 8: base ticks per snake move at level 0 (1..31).
- MIN_PERIOD, 2: fastest allowed period in ticks (1..START_PERIOD).
- SPEEDUP_EVERY, 4: apples eaten per level-up (1..15).
- FLASH_COUNT, 6: base ticks spent in the death flash (>=1).
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- start  in  1  start button level; rising edge = press.
- pause  in  1  pause button level; rising edge = toggle.
- step_done  in  1  one-cycle pulse from engine: move finished.
- step_collide  in  1  qualified by step_done: head hit body.
- step_ate  in  1  qualified by step_done: head took apple.
- step_req  out  1  move request, held until step_done.
- engine_clear  out  1  one-cycle pulse: engine reinitialises snake/apple/score.
- display_blank  out  1  1 = matrix outputs forced dark.
- state  out  3  current state encoding.
- level  out  4  speed level, saturates at 15.
- period  out  5  current ticks per move.

## Operation
- States: IDLE=0, CLEAR=1, RUN=2, STEP=3, PAUSE=4, DYING=5, OVER=6.
- Edge detect: start_d/pause_d registers. Both reset to 1, so a button held through reset is not a press.
- IDLE: start press -> CLEAR.
- OVER: start press -> CLEAR. Other inputs are ignored in both IDLE and OVER.
- CLEAR (one cycle):
  - engine_clear=1; level=0, period=START_PERIOD, apple count=0.
  - Prescaler and tick counter cleared.
  - Next state is RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; tick at terminal count.
  - Tick counter counts ticks. On the tick where it equals period-1, both counters clear -> STEP.
  - pause press -> PAUSE. Counters are held, not cleared.
- PAUSE: counters frozen; pause press -> RUN and counting resumes from held values. start ignored.
- STEP: step_req=1; prescaler held at 0; pause and start presses dropped. On step_done:
  - collide=1 -> DYING. Collide wins over ate.
  - ate=1: apple count+1. If it reaches SPEEDUP_EVERY: count=0, level=min(level+1,15), period=max(period-1,MIN_PERIOD). Then -> RUN.
  - Neither: -> RUN.
- step_done outside STEP is ignored. So are step_collide and step_ate when step_done=0.
- DYING:
  - Prescaler runs; flash counter counts ticks.
  - display_blank toggles at every tick, starting at 1 on entry.
  - After FLASH_COUNT ticks: display_blank=0 -> OVER.
- Reset values: state=IDLE, step_req=0, engine_clear=0, display_blank=0, level=0, period=START_PERIOD, all counters 0.
- Reset mid-STEP drops step_req asynchronously. The engine must abandon the move.

## Timing
- All outputs are registered from state/counters; no combinational input-to-output path.
- Start press seen at edge N -> state=CLEAR and engine_clear=1 after edge N+1 -> RUN after edge N+2.
- RUN entry to step_req high: START_PERIOD*TICK_DIV cycles at level 0.
- step_done sampled at edge N -> step_req low and state=RUN after edge N.
  - Level/period update visible in the same cycle as the return to RUN.
- Move interval = period*TICK_DIV + handshake latency. Time spent in STEP does not count toward the period.
- Engine may assert step_done no earlier than the cycle after step_req rises.

## Test plan
Bench parameters: TICK_DIV=4, START_PERIOD=3, MIN_PERIOD=1, SPEEDUP_EVERY=2, FLASH_COUNT=4.
- Reset, hold start=1 through release, keep start high -> stays IDLE, no engine_clear. Lower then raise start -> one engine_clear pulse, then RUN; step_req rises 12 cycles after RUN entry.
- Start game; answer each step_req with step_done after 3 cycles, collide=0, ate=0 -> step_req every 12 RUN cycles + handshake, level=0, period=3.
- Answer 4 consecutive steps with ate=1 -> level 1 then 2, period 3 -> 2 -> 1. Further level-ups keep period=1 while level rises to 15 and stays there.
- Pause mid-RUN at prescaler=2, wait 50 cycles, unpause -> step_req arrives exactly the remaining RUN cycles later. A pause press during STEP has no effect.
- step_done with collide=1 and ate=1 -> DYING, apple count unchanged. display_blank reads 1,0,1,0 over 16 cycles, then OVER with blank=0. Start press -> engine_clear, level=0, period=3.
- Assert reset while step_req=1 -> step_req, state, level drop to reset values before the next clk edge. A stray step_done in IDLE causes no transition.
